// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the hazard control slice: opcodes, register zero and
// the stall FSM state encoding.
package hazard_ctrl_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side signal bundle of the hazard control unit. The slave modport is
// the unit itself; the master modport is the pipeline that feeds it.
interface hazard_ctrl_unit_if #(
  parameter int CNT_W = 16
);

  logic [31:0]      id_inst;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [4:0]       ex_rd;
  logic             mem_mem_read;
  logic [4:0]       mem_rd;
  logic             branch_taken;
  logic             ext_stall;

  logic             pc_write;
  logic             if_id_write;
  logic             if_flush;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             stall_timeout;

  modport master (
    output id_inst, ex_mem_read, ex_reg_write, ex_rd, mem_mem_read, mem_rd,
           branch_taken, ext_stall,
    input  pc_write, if_id_write, if_flush, id_ex_bubble, stall_cycles,
           flush_count, stall_timeout
  );

  modport slave (
    input  id_inst, ex_mem_read, ex_reg_write, ex_rd, mem_mem_read, mem_rd,
           branch_taken, ext_stall,
    output pc_write, if_id_write, if_flush, id_ex_bubble, stall_cycles,
           flush_count, stall_timeout
  );

endinterface

// File: rtl/hazard_ctrl_unit_decode.sv
// Combinational decode of the ID-stage instruction into the register-use and
// control-flow flags the hazard detector needs.
module hazard_decode
  import hazard_ctrl_unit_pkg::*;
(
  input  logic [31:0] id_inst,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        is_br,
  output logic        is_j,
  output logic [4:0]  rs,
  output logic [4:0]  rt
);

  logic [5:0] op;
  logic       unused_imm;

  assign op         = id_inst[31:26];
  assign rs         = id_inst[25:21];
  assign rt         = id_inst[20:16];
  assign unused_imm = ^id_inst[15:0];

  assign is_j    = (op == OP_J) || (op == OP_JAL);
  assign is_br   = (op == OP_BEQ) || (op == OP_BNE);
  assign uses_rs = !is_j;
  assign uses_rt = op inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};

endmodule

// File: rtl/hazard_ctrl_unit.sv
// IF/ID stall and flush control: load-use and branch-operand hazard detection,
// a RUN/STALL FSM for multi-cycle stalls, performance counters and a watchdog.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_unit_if.slave bus
);

  localparam int WD_W = $clog2(MAX_STALL + 1);

  logic             uses_rs, uses_rt, is_br, is_j;
  logic [4:0]       rs, rt;
  logic             match_ex, match_mem;
  logic [1:0]       need;
  logic             hz_stall, do_flush;

  state_t           state;
  logic [1:0]       rem;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [WD_W-1:0]  consec;
  logic             timeout;

  hazard_decode u_decode (
    .id_inst (bus.id_inst),
    .uses_rs (uses_rs),
    .uses_rt (uses_rt),
    .is_br   (is_br),
    .is_j    (is_j),
    .rs      (rs),
    .rt      (rt)
  );

  assign match_ex  = (bus.ex_rd != REG_ZERO) &&
                     ((uses_rs && bus.ex_rd == rs) || (uses_rt && bus.ex_rd == rt));
  assign match_mem = (bus.mem_rd != REG_ZERO) &&
                     ((uses_rs && bus.mem_rd == rs) || (uses_rt && bus.mem_rd == rt));

  always_comb begin
    if (is_br && bus.ex_mem_read && match_ex)
      need = 2'd2;
    else if ((bus.ex_mem_read && match_ex) ||
             (is_br && bus.ex_reg_write && match_ex) ||
             (is_br && bus.mem_mem_read && match_mem))
      need = 2'd1;
    else
      need = 2'd0;
  end

  // Priority: reset forces Normal, then ext_stall freezes, then hazard stall, then flush.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.if_flush     = 1'b0;
    bus.id_ex_bubble = 1'b0;
    hz_stall         = 1'b0;
    do_flush         = 1'b0;
    if (rst) begin
      // outputs stay Normal while in reset
    end else if (bus.ext_stall) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
    end else if (state == ST_STALL || need != 2'd0) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_bubble = 1'b1;
      hz_stall         = 1'b1;
    end else if (is_j || (is_br && bus.branch_taken)) begin
      bus.if_flush = 1'b1;
      do_flush     = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      rem       <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      consec    <= '0;
      timeout   <= 1'b0;
    end else if (!bus.ext_stall) begin
      case (state)
        ST_RUN: begin
          if (need == 2'd2) begin
            state <= ST_STALL;
            rem   <= 2'd1;
          end
        end
        ST_STALL: begin
          rem <= rem - 2'd1;
          if (rem <= 2'd1) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase

      if (hz_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (do_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);

      // Watchdog counts consecutive hazard stalls; any non-stall cycle restarts it.
      if (hz_stall) begin
        if (consec != WD_W'(MAX_STALL)) consec <= consec + WD_W'(1);
        if (consec >= WD_W'(MAX_STALL - 1)) timeout <= 1'b1;
      end else begin
        consec <= '0;
      end
    end
  end

  assign bus.stall_cycles  = stall_cnt;
  assign bus.flush_count   = flush_cnt;
  assign bus.stall_timeout = timeout;

endmodule
